// File: rtl/rf_2p_fifo.sv
// ============================================================================
// rf_2p_fifo : synchronous FIFO over a two-port register file
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rf_2p_fifo #(
    parameter int unsigned WORD_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned AFULL_TH   = 56
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [WORD_WIDTH-1:0] wr_dat_i,
    output logic                  full_o,
    output logic                  afull_o,
    input  logic                  rd_en_i,
    output logic [WORD_WIDTH-1:0] rd_dat_o,
    output logic                  rd_val_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   cnt_o,
    output logic                  ovf_o,
    output logic                  udf_o
);

    localparam int unsigned          c_DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]  c_FULL_CNT  = (ADDR_WIDTH+1)'(c_DEPTH);
    localparam logic [ADDR_WIDTH:0]  c_AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0]  c_CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE  = ADDR_WIDTH'(1);

    logic [WORD_WIDTH-1:0] r_mem [c_DEPTH];

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  r_rd_val;
    logic [WORD_WIDTH-1:0] r_rd_dat;

    logic w_full;
    logic w_empty;
    logic w_active;
    logic w_wr_acc;
    logic w_rd_acc;

    // Status is decoded from the registered count only, never from the requests.
    assign w_full  = (r_cnt == c_FULL_CNT);
    assign w_empty = (r_cnt == '0);

    // Requests in a flush or reset cycle are dropped entirely.
    assign w_active = rstn & ~flush_i;
    assign w_wr_acc = w_active & wr_en_i & ~w_full;
    assign w_rd_acc = w_active & rd_en_i & ~w_empty;

    // Register-file write port; storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_rd_val <= 1'b0;
            r_rd_dat <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_rd_val <= 1'b0;
        end else begin
            r_rd_val <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                r_rd_dat <= r_mem[r_rd_ptr];
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
                2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
            if (wr_en_i && w_full) begin
                r_ovf <= 1'b1;
            end
            if (rd_en_i && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign full_o   = w_full;
    assign empty_o  = w_empty;
    assign afull_o  = (r_cnt >= c_AFULL_CNT);
    assign cnt_o    = r_cnt;
    assign ovf_o    = r_ovf;
    assign udf_o    = r_udf;
    assign rd_val_o = r_rd_val;
    assign rd_dat_o = r_rd_dat;

endmodule

`default_nettype wire

// File: tb/tb_rf_2p_fifo.sv
// ============================================================================
// tb_rf_2p_fifo : randomized bench for rf_2p_fifo against a queue model
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_rf_2p_fifo;

    localparam int unsigned c_WW    = 24;
    localparam int unsigned c_AW    = 6;
    localparam int unsigned c_DEPTH = 64;
    localparam int unsigned c_AFULL = 56;

    logic                clk = 1'b0;
    logic                rstn;
    logic                flush_i;
    logic                wr_en_i;
    logic [c_WW-1:0]     wr_dat_i;
    logic                full_o;
    logic                afull_o;
    logic                rd_en_i;
    logic [c_WW-1:0]     rd_dat_o;
    logic                rd_val_o;
    logic                empty_o;
    logic [c_AW:0]       cnt_o;
    logic                ovf_o;
    logic                udf_o;

    rf_2p_fifo #(
        .WORD_WIDTH (c_WW),
        .ADDR_WIDTH (c_AW),
        .AFULL_TH   (c_AFULL)
    ) u_dut (
        .clk      (clk),
        .rstn     (rstn),
        .flush_i  (flush_i),
        .wr_en_i  (wr_en_i),
        .wr_dat_i (wr_dat_i),
        .full_o   (full_o),
        .afull_o  (afull_o),
        .rd_en_i  (rd_en_i),
        .rd_dat_o (rd_dat_o),
        .rd_val_o (rd_val_o),
        .empty_o  (empty_o),
        .cnt_o    (cnt_o),
        .ovf_o    (ovf_o),
        .udf_o    (udf_o)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, plus the observable flags.
    logic [c_WW-1:0] m_q [$];
    logic            m_ovf;
    logic            m_udf;
    logic            m_val;
    logic [c_WW-1:0] m_dat;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic rn, input logic fl, input logic wr,
                              input logic [c_WW-1:0] din, input logic rd);
        int sz;
        sz = m_q.size();
        if (!rn) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_val = 1'b0;
            m_dat = '0;
        end else if (fl) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_val = 1'b0;
        end else begin
            m_val = 1'b0;
            if (rd) begin
                if (sz > 0) begin
                    m_dat = m_q.pop_front();
                    m_val = 1'b1;
                end else begin
                    m_udf = 1'b1;
                end
            end
            if (wr) begin
                if (sz < c_DEPTH) m_q.push_back(din);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        int sz;
        sz = m_q.size();
        chk("cnt",   32'(cnt_o),    32'(sz));
        chk("empty", 32'(empty_o),  32'(sz == 0));
        chk("full",  32'(full_o),   32'(sz == c_DEPTH));
        chk("afull", 32'(afull_o),  32'(sz >= c_AFULL));
        chk("ovf",   32'(ovf_o),    32'(m_ovf));
        chk("udf",   32'(udf_o),    32'(m_udf));
        chk("rdval", 32'(rd_val_o), 32'(m_val));
        chk("rddat", 32'(rd_dat_o), 32'(m_dat));
    endtask

    // One clock: apply inputs, advance, update model, compare away from the edge.
    task automatic step(input logic rn, input logic fl, input logic wr,
                        input logic [c_WW-1:0] din, input logic rd);
        rstn     = rn;
        flush_i  = fl;
        wr_en_i  = wr;
        wr_dat_i = din;
        rd_en_i  = rd;
        @(posedge clk);
        #1;
        model_step(rn, fl, wr, din, rd);
        check_all();
    endtask

    task automatic wr1(input logic [c_WW-1:0] d); step(1, 0, 1, d, 0); endtask
    task automatic rd1();                         step(1, 0, 0, '0, 1); endtask
    task automatic idle();                        step(1, 0, 0, '0, 0); endtask
    task automatic flush1();                      step(1, 1, 0, '0, 0); endtask

    initial begin
        m_ovf = 1'b0; m_udf = 1'b0; m_val = 1'b0; m_dat = '0;
        rstn = 1'b0; flush_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0; wr_dat_i = '0;

        // Reset with requests present: reset must win.
        step(0, 1, 1, 24'h123456, 1);
        step(0, 0, 0, '0, 0);
        idle();

        // Fill 0..63, then one write too many.
        for (int i = 0; i < 64; i++) wr1(24'(i));
        wr1(24'hABCDEF);

        // Drain in order, then one read too many.
        for (int i = 0; i < 64; i++) rd1();
        rd1();
        idle();

        // Simultaneous read+write at full.
        flush1();
        for (int i = 0; i < 64; i++) wr1(24'($urandom));
        step(1, 0, 1, 24'h5A5A5A, 1);
        // Simultaneous read+write at empty, then read the written word.
        flush1();
        step(1, 0, 1, 24'h0C0FFE, 1);
        rd1();
        idle();

        // Random streaming with wrap-around, occupancy held in 1..63.
        flush1();
        for (int i = 0; i < 32; i++) wr1(24'($urandom));
        for (int i = 0; i < 200; i++) begin
            logic w, r;
            w = 1'($urandom);
            r = 1'($urandom);
            if (m_q.size() <= 1)  r = 1'b0;
            if (m_q.size() >= 63) w = 1'b0;
            step(1, 0, w, 24'($urandom), r);
        end

        // Flush with cnt 10 and ovf set, requests in the flush cycle ignored.
        flush1();
        for (int i = 0; i < 64; i++) wr1(24'($urandom));
        wr1(24'h111111);
        for (int i = 0; i < 54; i++) rd1();
        step(1, 1, 1, 24'h222222, 1);
        wr1(24'h333333);
        rd1();
        idle();

        // Reset mid-stream while a read is accepted.
        flush1();
        for (int i = 0; i < 20; i++) wr1(24'(100 + i));
        step(0, 0, 0, '0, 1);
        for (int i = 0; i < 5; i++) wr1(24'($urandom));
        for (int i = 0; i < 6; i++) rd1();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rf_2p_fifo.md
# rf_2p_fifo

Parametrised synchronous FIFO. Storage is a two-port register file: port A reads, port B writes. Adds what a bare register file lacks: pointer management, full/empty/almost-full status, occupancy count, a flush, and sticky overflow/underflow flags. Used wherever encoder pipeline stages hand off bursts of words through local two-port RF storage.

## Interface
- Word_Width, 24, data word width in bits
- Addr_Width, 6, address width; depth DEPTH = 2^Addr_Width
- Afull_Th, 56, almost-full threshold in words (1..DEPTH)
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  synchronous active-low reset
- flush_i  in  1  synchronous clear of pointers, count and flags
- wr_en_i  in  1  write request
- wr_dat_i  in  Word_Width  write data
- full_o  out  1  count == DEPTH
- afull_o  out  1  count >= Afull_Th
- rd_en_i  in  1  read request
- rd_dat_o  out  Word_Width  read data, valid when rd_val_o = 1
- rd_val_o  out  1  rd_dat_o carries the word popped the previous cycle
- empty_o  out  1  count == 0
- cnt_o  out  Addr_Width+1  current occupancy, 0..DEPTH
- ovf_o  out  1  sticky: write attempted while full
- udf_o  out  1  sticky: read attempted while empty

## Operation
- State: wr_ptr and rd_ptr (Addr_Width bits each, wrap naturally DEPTH-1 -> 0), cnt (Addr_Width+1 bits), ovf, udf, rd_val, rd_dat.
- Accepted write: wr_acc = wr_en_i & ~full_o. On wr_acc, write wr_dat_i to RF[wr_ptr] and increment wr_ptr.
- Accepted read: rd_acc = rd_en_i & ~empty_o. On rd_acc, read RF[rd_ptr] and increment rd_ptr. Data appears on rd_dat_o next cycle with rd_val_o = 1.
- cnt update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- full_o, empty_o and afull_o are decoded combinationally from registered cnt. They reflect the state at the start of the cycle.
- Full and simultaneous read+write: the read is accepted and the write is rejected (full gates it). ovf sets; cnt goes DEPTH -> DEPTH-1.
- Empty and simultaneous read+write: the write is accepted and the read is rejected. udf sets; cnt goes 0 -> 1. There is no write-to-read bypass.
- A rejected write does not touch RF or wr_ptr. A rejected read does not move rd_ptr and gives rd_val_o = 0 the next cycle.
- ovf_o and udf_o stay high until reset or flush.
- rd_dat_o holds its last value when rd_val_o = 0.
- flush_i: next cycle, pointers = 0, cnt = 0, ovf = udf = 0, rd_val = 0. Any wr_en_i/rd_en_i in the flush cycle is ignored and sets no flag. RF contents are not cleared.
- The RF array is never reset. Contents after reset are undefined and unreachable through the interface.

## Timing
- Reset values (rstn low at a rising edge): wr_ptr = rd_ptr = 0, cnt_o = 0, empty_o = 1, full_o = 0, afull_o = 0, ovf_o = udf_o = 0, rd_val_o = 0, rd_dat_o = 0. Reset takes priority over flush_i and all requests.
- Reset mid-operation: in-flight data is discarded. If a read was accepted in the cycle reset is sampled, rd_val_o = 0 the next cycle.
- Read latency: 1 cycle from accepted rd_en_i to rd_val_o/rd_dat_o.
- Write-to-read latency: a word written in cycle N updates cnt at N+1, where empty_o falls. A read can be accepted at N+1, and the data is valid at N+2.
- Sustained throughput: one write and one read per cycle whenever the FIFO is neither full nor empty.
- Status outputs change only on clock edges; there is no combinational path from wr_en_i/rd_en_i to them.

## Test plan
- Reset then fill: defaults (Addr_Width 6, Afull_Th 56). Write 0..63 on 64 consecutive cycles. Required: afull_o rises the cycle after write 55 (cnt 56); full_o rises after write 63; cnt_o = 64. A 65th write sets ovf_o, and cnt_o stays 64.
- Drain in order: from full, assert rd_en_i for 64 cycles. Required: rd_dat_o = 0,1,...,63 on consecutive cycles with rd_val_o = 1, empty_o = 1 after the last pop. One more rd_en_i sets udf_o, and rd_val_o stays 0.
- Simultaneous boundaries: at cnt 64, rd+wr gives cnt 63, ovf_o = 1, and the read word is correct. At cnt 0, rd+wr gives cnt 1, udf_o = 1, and the next read returns the written word.
- Wrap-around streaming: 200 cycles of random wr/rd, keeping 1..63 words stored. Required: data order matches a reference queue, cnt_o is exact every cycle, no flags set.
- Flush: with cnt 10 and ovf_o = 1, pulse flush_i together with wr_en_i and rd_en_i. Next cycle: cnt_o = 0, empty_o = 1, ovf_o = 0, udf_o = 0, rd_val_o = 0. A subsequent write/read returns the new word.
- Reset mid-stream: drop rstn for 1 cycle while cnt = 20 and a read is accepted. Required: all outputs at reset values the next cycle, and the FIFO operates normally afterwards.
